// File: rtl/fifo_stream_pkg.sv
// Shared types and constants for the FIFO drain / word-packing stream.
//   FIFO_WIDTH : width of one FIFO word
//   BEAT_WIDTH : width of one packed output beat (two FIFO words)
//   BUF_DEPTH  : entries in the output skid buffer (fixed at 2)
//   beat_t     : one buffered beat, data plus its end-of-frame marker
package fifo_stream_pkg;

  localparam int FIFO_WIDTH = 16;
  localparam int BEAT_WIDTH = 2 * FIFO_WIDTH;
  localparam int BUF_DEPTH  = 2;

  typedef struct packed {
    logic [BEAT_WIDTH-1:0] data;
    logic                  last;
  } beat_t;

endpackage

// File: rtl/fifo_word_packer_if.sv
// Bundle of the packer's FIFO read side and its output stream.
//   fifo_data_out/fifo_empty/fifo_underflow : from the FIFO
//   fifo_rd_en                              : pop request to the FIFO
//   m_data/m_valid/m_last/m_ready           : valid/ready output stream
//   err_underflow                           : sticky underflow indication
// Modports:
//   master : the packer (drives fifo_rd_en and the stream outputs)
//   slave  : the environment (FIFO and consumer)
interface fifo_word_packer_if;
  import fifo_stream_pkg::*;

  logic [FIFO_WIDTH-1:0] fifo_data_out;
  logic                  fifo_empty;
  logic                  fifo_underflow;
  logic                  fifo_rd_en;
  logic [BEAT_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;
  logic                  err_underflow;

  modport master (
    input  fifo_data_out, fifo_empty, fifo_underflow, m_ready,
    output fifo_rd_en, m_data, m_valid, m_last, err_underflow
  );

  modport slave (
    output fifo_data_out, fifo_empty, fifo_underflow, m_ready,
    input  fifo_rd_en, m_data, m_valid, m_last, err_underflow
  );

endinterface

// File: rtl/fifo_skid_buf.sv
// Two-entry beat buffer between the packer and the output stream.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_beat at the tail (caller guarantees room)
//   push_beat  : beat to write
//   pop        : drop the head entry (caller guarantees count != 0)
//   head       : current head entry
//   count      : number of occupied entries (0..2)
// Push and pop may occur in the same cycle at any occupancy.
module fifo_skid_buf
  import fifo_stream_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  beat_t      push_beat,
  input  logic       pop,
  output beat_t      head,
  output logic [1:0] count
);

  beat_t mem [BUF_DEPTH];
  logic  wr_ptr;
  logic  rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage is only two entries, so it is reset along with the
      // pointers; that is what makes m_data/m_last read 0 straight out of reset.
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every update here sees
      // the pre-edge values of wr_ptr/rd_ptr/count regardless of statement order.
      if (push) begin
        mem[wr_ptr] <= push_beat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_word_packer.sv
// Drain stage for the sync FIFO: pops 16-bit words, packs consecutive pairs
// into 32-bit beats ([15:0] older word, [31:16] newer word) and presents them
// on a valid/ready stream with a per-frame last marker.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fifo_word_packer_if.master (FIFO read side + output stream)
// Parameter:
//   FRAME_BEATS : beats per frame; m_last is set on the final beat (>= 1)
// The FIFO returns data one cycle after fifo_rd_en. Reads are only issued when
// the FIFO is non-empty and the word is guaranteed somewhere to land, so
// backpressure never drops data.
module fifo_word_packer #(
  parameter int FRAME_BEATS = 4
) (
  input logic               clk,
  input logic               rst_n,
  fifo_word_packer_if.master bus
);
  import fifo_stream_pkg::*;

  localparam int                CNT_W    = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FRAME_BEATS - 1);

  logic                  inflight_q;   // a pop was issued last cycle
  logic                  half_valid_q; // half_q holds the older word of a pair
  logic [FIFO_WIDTH-1:0] half_q;
  logic [CNT_W-1:0]      frame_cnt_q;  // beat index within the frame, push order
  logic                  err_q;

  logic       rd_en;
  logic       pop;
  logic       push;
  logic       capture_ok;
  beat_t      push_beat;
  beat_t      head;
  logic [1:0] buf_count;
  logic [2:0] free_slots;
  logic [3:0] room;
  logic [3:0] need;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    pop        = 1'b0;
    free_slots = '0;
    room       = '0;
    need       = '0;
    rd_en      = 1'b0;
    capture_ok = 1'b0;
    push       = 1'b0;
    push_beat  = '0;

    pop = (buf_count != 2'd0) && bus.m_ready;

    // Word-level credit. The buffer holds 2*free_slots words once this cycle's
    // accepted beat leaves; the half register is one more word of storage.
    // Words already committed are the held half and the in-flight word, so a
    // new read fits when 2*free_slots >= half_valid + inflight. With a full
    // buffer this still lets one word land in the half register.
    free_slots = 3'(BUF_DEPTH) - {1'b0, buf_count} + {2'b0, pop};
    room       = {free_slots, 1'b0};
    need       = {3'b0, half_valid_q} + {3'b0, inflight_q};
    rd_en      = !bus.fifo_empty && (room >= need);

    // A word arriving with the underflow flag is discarded, never packed.
    capture_ok = inflight_q && !bus.fifo_underflow;
    push       = capture_ok && half_valid_q;

    push_beat.data = {bus.fifo_data_out, half_q};
    push_beat.last = (frame_cnt_q == LAST_CNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q   <= 1'b0;
      half_valid_q <= 1'b0;
      half_q       <= '0;
      frame_cnt_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      inflight_q <= rd_en;

      if (inflight_q && bus.fifo_underflow) begin
        err_q <= 1'b1;
      end

      if (capture_ok) begin
        if (!half_valid_q) begin
          half_q       <= bus.fifo_data_out;
          half_valid_q <= 1'b1;
        end else begin
          half_valid_q <= 1'b0;
        end
      end

      // Counted at push time: beats leave the buffer in push order, so the
      // n-th pushed beat is the n-th accepted beat and its last flag is exact
      // even when several beats are queued under backpressure.
      if (push) begin
        frame_cnt_q <= (frame_cnt_q == LAST_CNT) ? '0 : frame_cnt_q + CNT_W'(1);
      end
    end
  end

  fifo_skid_buf u_skid_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_beat (push_beat),
    .pop       (pop),
    .head      (head),
    .count     (buf_count)
  );

  assign bus.fifo_rd_en    = rd_en;
  assign bus.m_valid       = (buf_count != 2'd0);
  assign bus.m_data        = head.data;
  assign bus.m_last        = head.last;
  assign bus.err_underflow = err_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: a behavioural FIFO with one-cycle read latency
// feeds the DUT; directed stimulus pushes hand-computed expected beats into a
// scoreboard queue, and a separate monitor compares every accepted beat.
module tb_fifo_word_packer;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  localparam logic [31:0] T3_BEATS [8] = '{
    32'h0001_0000, 32'h0003_0002, 32'h0005_0004, 32'h0007_0006,
    32'h0009_0008, 32'h000B_000A, 32'h000D_000C, 32'h000F_000E
  };
  localparam logic T3_LAST [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fifo_word_packer_if bus ();

  fifo_word_packer #(.FRAME_BEATS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  logic [15:0] fifo_q [$];
  exp_t        exp_q [$];
  logic        uf_next = 1'b0;

  int n_checks    = 0;
  int n_err       = 0;
  int rd_total    = 0;
  int valid_total = 0;
  int empty_reads = 0;
  int overread    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO model: a pop requested in cycle t presents its word during t+1.
  initial begin
    logic pop_now;
    bus.fifo_data_out  = '0;
    bus.fifo_empty     = 1'b1;
    bus.fifo_underflow = 1'b0;
    forever begin
      @(negedge clk);
      pop_now = bus.fifo_rd_en;
      @(posedge clk);
      #1;
      bus.fifo_underflow = 1'b0;
      if (pop_now) begin
        if (fifo_q.size() == 0) begin
          overread++;
        end else begin
          bus.fifo_data_out = fifo_q.pop_front();
          if (uf_next) begin
            bus.fifo_underflow = 1'b1;
            uf_next = 1'b0;
          end
        end
      end
      bus.fifo_empty = (fifo_q.size() == 0);
    end
  end

  // Monitor / scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.fifo_rd_en) rd_total++;
        if (bus.fifo_rd_en && bus.fifo_empty) empty_reads++;
        if (bus.m_valid) valid_total++;
        if (bus.m_valid && bus.m_ready) begin
          check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("beat_data", bus.m_data, e.data);
            check("beat_last", 32'(bus.m_last), 32'(e.last));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic expect_beat(input logic [31:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.m_ready = 1'b0;
    uf_next = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    step(3);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int cyc = 0;
    while (!(exp_q.size() == 0 && fifo_q.size() == 0 && !bus.m_valid) && cyc < budget) begin
      step(1);
      cyc++;
    end
    check(name, 32'(cyc < budget), 32'd1);
  endtask

  initial begin
    int rd0;
    int v0;
    bus.m_ready = 1'b0;

    // 1: reset values while held in reset
    step(3);
    check("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_m_data", bus.m_data, 32'd0);
    check("rst_m_last", 32'(bus.m_last), 32'd0);
    check("rst_err", 32'(bus.err_underflow), 32'd0);
    rst_n = 1'b1;
    step(1);

    // 2: pack order
    rd0 = rd_total;
    v0  = valid_total;
    bus.m_ready = 1'b1;
    fifo_q.push_back(16'h1111);
    fifo_q.push_back(16'h2222);
    expect_beat(32'h2222_1111, 1'b0);
    wait_idle("t2_drain", 50);
    step(2);
    check("t2_rd_pulses", 32'(rd_total - rd0), 32'd2);
    check("t2_valid_cycles", 32'(valid_total - v0), 32'd1);

    // 3: frame marking over 16 words
    do_reset();
    bus.m_ready = 1'b1;
    for (int k = 0; k < 16; k++) fifo_q.push_back(16'(k));
    for (int b = 0; b < 8; b++) expect_beat(T3_BEATS[b], T3_LAST[b]);
    wait_idle("t3_drain", 100);

    // 4: backpressure with 8 words queued
    do_reset();
    rd0 = rd_total;
    for (int k = 0; k < 8; k++) fifo_q.push_back(16'h00A0 + 16'(k));
    expect_beat(32'h00A1_00A0, 1'b0);
    expect_beat(32'h00A3_00A2, 1'b0);
    expect_beat(32'h00A5_00A4, 1'b0);
    expect_beat(32'h00A7_00A6, 1'b1);
    step(20);
    check("t4_rd_pulses_stalled", 32'(rd_total - rd0), 32'd5);
    check("t4_rd_en_stalled", 32'(bus.fifo_rd_en), 32'd0);
    check("t4_m_valid_stalled", 32'(bus.m_valid), 32'd1);
    check("t4_m_data_stalled", bus.m_data, 32'h00A1_00A0);
    bus.m_ready = 1'b1;
    wait_idle("t4_drain", 100);
    check("t4_rd_pulses_total", 32'(rd_total - rd0), 32'd8);

    // 5: FIFO empty mid-pair
    do_reset();
    bus.m_ready = 1'b1;
    rd0 = rd_total;
    fifo_q.push_back(16'h00B0);
    fifo_q.push_back(16'h00B1);
    fifo_q.push_back(16'h00B2);
    expect_beat(32'h00B1_00B0, 1'b0);
    step(14);
    check("t5_rd_pulses_gap", 32'(rd_total - rd0), 32'd3);
    check("t5_m_valid_gap", 32'(bus.m_valid), 32'd0);
    check("t5_first_beat_out", 32'(exp_q.size()), 32'd0);
    fifo_q.push_back(16'h00B3);
    expect_beat(32'h00B3_00B2, 1'b0);
    wait_idle("t5_drain", 50);

    // 6: underflow discards the word and sets the sticky flag
    do_reset();
    bus.m_ready = 1'b1;
    uf_next = 1'b1;
    fifo_q.push_back(16'h00C0);
    fifo_q.push_back(16'h00C1);
    fifo_q.push_back(16'h00C2);
    expect_beat(32'h00C2_00C1, 1'b0);
    wait_idle("t6_drain_a", 50);
    check("t6_err_set", 32'(bus.err_underflow), 32'd1);
    fifo_q.push_back(16'h00C3);
    fifo_q.push_back(16'h00C4);
    expect_beat(32'h00C4_00C3, 1'b0);
    wait_idle("t6_drain_b", 50);
    check("t6_err_held", 32'(bus.err_underflow), 32'd1);
    do_reset();
    check("t6_err_cleared", 32'(bus.err_underflow), 32'd0);

    // 7: asynchronous reset mid-beat drops m_valid before the next edge
    fifo_q.push_back(16'h00D0);
    fifo_q.push_back(16'h00D1);
    step(8);
    check("t7_m_valid_before", 32'(bus.m_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t7_m_valid_async", 32'(bus.m_valid), 32'd0);
    check("t7_m_data_async", bus.m_data, 32'd0);
    step(2);
    rst_n = 1'b1;
    bus.m_ready = 1'b1;
    step(5);
    check("t7_discarded", 32'(bus.m_valid), 32'd0);

    check("fifo_overread", 32'(overread), 32'd0);
    check("rd_while_empty", 32'(empty_reads), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
